multi_timer: RTL



---
 rtl/multi_timer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// Multi-channel bus-mapped down-counter timer sharing one prescaler and one interrupt line.
// Optional MULTI_TIMER_SNAPSHOT_EN: an off-1 read latches COUNT[15:8] for a coherent off-2 read.
module multi_timer #(
  parameter logic [7:0] BASE_ADDR   = 8'hF0,
  parameter int         NUM_CH      = 2,
  parameter int         CNT_WIDTH   = 16,
  parameter int         PRESCALE    = 100000,
  parameter int         INIT_PERIOD = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int                   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]        PRE_MAX = PW'(PRESCALE - 1);
  localparam int                   WIN     = 4 * NUM_CH;
  localparam logic [CNT_WIDTH-1:0] INIT_P  = CNT_WIDTH'(INIT_PERIOD);

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [8:0]    w_rel9;
  logic          w_in_win;
  logic [1:0]    w_ch;
  logic [1:0]    w_off;
  logic [7:0]    w_rdata;
  logic [7:0]    w_ctrl_rd [4];
  logic [15:0]   w_cnt16   [4];
  logic [7:0]    w_hi_rd   [4];
  logic [3:0]    w_pend;
  logic          r_oe;
  logic [7:0]    r_rdata;
  logic          r_raise;

  assign w_tick = (r_presc == PRE_MAX);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A 9-bit difference keeps addresses below BASE_ADDR out of the window.
  assign w_rel9   = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign w_in_win = (w_rel9 < 9'(WIN));
  assign w_ch     = w_rel9[3:2];
  assign w_off    = w_rel9[1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    if (gi < NUM_CH) begin : g_on
      logic                 w_sel, w_wr_ctrl, w_wr_lo, w_wr_hi, w_wr_stat;
      logic                 w_load, w_run, w_last, w_expire;
      logic                 r_en, r_mode, r_ie, r_pend;
      logic [7:0]           r_shadow;
      logic [CNT_WIDTH-1:0] r_period, r_count;
      logic [15:0]          w_cnt_ext;

      assign w_sel     = w_in_win && (w_ch == 2'(gi));
      assign w_wr_ctrl = BUS_WE && w_sel && (w_off == 2'd0);
      assign w_wr_lo   = BUS_WE && w_sel && (w_off == 2'd1);
      assign w_wr_hi   = BUS_WE && w_sel && (w_off == 2'd2);
      assign w_wr_stat = BUS_WE && w_sel && (w_off == 2'd3);
      assign w_load    = w_wr_ctrl && ((BUS_DATA[0] && !r_en) || BUS_DATA[7]);
      // A load swallows a coincident tick, so it can never produce an expiry.
      assign w_run     = w_tick && r_en && (r_period != '0) && !w_load;
      assign w_last    = (r_count <= CNT_WIDTH'(1));
      assign w_expire  = w_run && w_last;
      assign w_cnt_ext = 16'(r_count);

      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_en     <= 1'b0;
          r_mode   <= 1'b0;
          r_ie     <= 1'b0;
          r_pend   <= 1'b0;
          r_shadow <= '0;
          r_period <= INIT_P;
          r_count  <= '0;
        end else begin
          if (w_wr_lo) r_shadow <= BUS_DATA;
          if (w_wr_hi) r_period <= CNT_WIDTH'({BUS_DATA, r_shadow});
          if (w_load) begin
            r_count <= r_period;
          end else if (w_run) begin
            if (w_last) r_count <= r_mode ? r_period : '0;
            else        r_count <= r_count - CNT_WIDTH'(1);
          end
          if (w_wr_ctrl) begin
            r_en   <= BUS_DATA[0];
            r_mode <= BUS_DATA[1];
            r_ie   <= BUS_DATA[2];
          end else if (w_expire && !r_mode) begin
            r_en <= 1'b0;
          end
          if (w_expire && r_ie) begin
            r_pend <= 1'b1;
          end else if (BUS_INTERRUPT_ACK || w_wr_stat) begin
            r_pend <= 1'b0;
          end
        end
      end

      assign w_ctrl_rd[gi] = {5'b0, r_ie, r_mode, r_en};
      assign w_cnt16[gi]   = w_cnt_ext;
      assign w_pend[gi]    = r_pend;

`ifdef MULTI_TIMER_SNAPSHOT_EN
      logic [7:0] r_snap;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_snap <= '0;
        end else if (w_sel && !BUS_WE && (w_off == 2'd1)) begin
          r_snap <= w_cnt_ext[15:8];
        end
      end
      assign w_hi_rd[gi] = r_snap;
`else
      assign w_hi_rd[gi] = w_cnt_ext[15:8];
`endif
    end else begin : g_off
      assign w_ctrl_rd[gi] = 8'h00;
      assign w_cnt16[gi]   = 16'h0000;
      assign w_hi_rd[gi]   = 8'h00;
      assign w_pend[gi]    = 1'b0;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (w_off)
      2'd0:    w_rdata = w_ctrl_rd[w_ch];
      2'd1:    w_rdata = w_cnt16[w_ch][7:0];
      2'd2:    w_rdata = w_hi_rd[w_ch];
      default: w_rdata = {7'b0, w_pend[w_ch]};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_oe    <= 1'b0;
      r_rdata <= 8'h00;
      r_raise <= 1'b0;
    end else begin
      r_oe    <= w_in_win && !BUS_WE;
      r_rdata <= w_rdata;
      r_raise <= |w_pend;
    end
  end

  assign BUS_DATA            = r_oe ? r_rdata : 8'bz;
  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule
